// File: rtl/csi_sequence_parser.sv
`default_nettype none
// ============================================================================
//  Module   : csi_sequence_parser
//  Purpose  : Terminal escape-sequence front end. Consumes one byte per
//             dataReady strobe and emits decoded events: a plain character,
//             a two-byte ESC command, or a full ANSI CSI sequence with up to
//             MAX_PARAMS saturating numeric parameters, default flags,
//             '?' private marker and any final byte in 0x40-0x7E.
//  Ports    : clk, rst (sync, active-low)
//             data[7:0], dataReady            - incoming byte stream
//             cmdValid                        - one-cycle event strobe
//             cmdKind (0 CHAR, 1 ESC, 2 CSI)  - event type
//             cmdFinal                        - char / ESC byte / CSI final
//             cmdPrivate, paramCount, params, paramDefault, paramOverflow
//                                             - CSI details (cleared for
//                                               CHAR and ESC events)
//             busy                            - parser is mid-sequence
//  Revision : 1.0 - initial release
// ============================================================================
module csi_sequence_parser #(
    parameter int MAX_PARAMS = 4,
    parameter int PARAM_W    = 8,
    parameter int CNT_W      = $clog2(MAX_PARAMS + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data,
    input  logic                          dataReady,
    output logic                          cmdValid,
    output logic [1:0]                    cmdKind,
    output logic [7:0]                    cmdFinal,
    output logic                          cmdPrivate,
    output logic [CNT_W-1:0]              paramCount,
    output logic [MAX_PARAMS*PARAM_W-1:0] params,
    output logic [MAX_PARAMS-1:0]         paramDefault,
    output logic                          paramOverflow,
    output logic                          busy
);

    localparam logic [1:0] c_S_IDLE      = 2'd0;
    localparam logic [1:0] c_S_ESC       = 2'd1;
    localparam logic [1:0] c_S_CSI_ENTRY = 2'd2;
    localparam logic [1:0] c_S_CSI_PARAM = 2'd3;

    localparam logic [1:0] c_KIND_CHAR = 2'd0;
    localparam logic [1:0] c_KIND_ESC  = 2'd1;
    localparam logic [1:0] c_KIND_CSI  = 2'd2;

    localparam int             c_AW      = PARAM_W + 4;
    localparam logic [c_AW-1:0] c_SAT    = {4'b0000, {PARAM_W{1'b1}}};
    localparam logic [CNT_W-1:0] c_MAXP  = CNT_W'(MAX_PARAMS);

    // State and working (in-flight) sequence registers
    logic [1:0]                    r_state;
    logic [MAX_PARAMS*PARAM_W-1:0] r_wparams;
    logic [MAX_PARAMS-1:0]         r_wdef;
    logic [CNT_W-1:0]              r_idx;     // current slot, saturates at MAX_PARAMS
    logic                          r_seen;    // any digit or ';' seen
    logic                          r_priv;
    logic                          r_ovf;

    // Registered outputs
    logic                          r_valid;
    logic [1:0]                    r_kind;
    logic [7:0]                    r_final;
    logic                          r_opriv;
    logic [CNT_W-1:0]              r_ocount;
    logic [MAX_PARAMS*PARAM_W-1:0] r_oparams;
    logic [MAX_PARAMS-1:0]         r_odef;
    logic                          r_oovf;
    logic                          r_busy;

    // Next-state signals
    logic [1:0]                    w_state_n;
    logic [MAX_PARAMS*PARAM_W-1:0] w_wparams_n;
    logic [MAX_PARAMS-1:0]         w_wdef_n;
    logic [CNT_W-1:0]              w_idx_n;
    logic                          w_seen_n;
    logic                          w_priv_n;
    logic                          w_ovf_n;
    logic                          w_emit;
    logic [1:0]                    w_kind;

    // Byte classification
    logic w_is_cancel;   // CAN / SUB
    logic w_is_esc;
    logic w_is_c0;       // C0 control executed in place
    logic w_is_digit;
    logic w_is_final;

    // Digit accumulation for the current slot
    logic [PARAM_W-1:0] w_cur;
    logic [c_AW-1:0]    w_acc;
    logic [PARAM_W-1:0] w_sat;
    logic [CNT_W-1:0]   w_pcount;

    assign w_is_cancel = (data == 8'h18) || (data == 8'h1A);
    assign w_is_esc    = (data == 8'h1B);
    assign w_is_c0     = (data < 8'h20) && !w_is_cancel && !w_is_esc;
    assign w_is_digit  = (data >= 8'h30) && (data <= 8'h39);
    assign w_is_final  = (data >= 8'h40) && (data <= 8'h7E);

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < MAX_PARAMS; i++) begin
            if (CNT_W'(i) == r_idx) begin
                w_cur = r_wparams[i*PARAM_W +: PARAM_W];
            end
        end
    end

    // Wide multiply-add so the saturation compare never sees a wrapped value
    assign w_acc = c_AW'(w_cur) * c_AW'(10) + c_AW'(data[3:0]);
    assign w_sat = (w_acc > c_SAT) ? {PARAM_W{1'b1}} : w_acc[PARAM_W-1:0];

    // Parameter count of the sequence collected so far
    assign w_pcount = !r_seen            ? '0     :
                      (r_idx >= c_MAXP)  ? c_MAXP : r_idx + CNT_W'(1);

    always_comb begin
        w_state_n   = r_state;
        w_wparams_n = r_wparams;
        w_wdef_n    = r_wdef;
        w_idx_n     = r_idx;
        w_seen_n    = r_seen;
        w_priv_n    = r_priv;
        w_ovf_n     = r_ovf;
        w_emit      = 1'b0;
        w_kind      = c_KIND_CHAR;

        if (dataReady) begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_is_esc) begin
                        w_state_n = c_S_ESC;
                    end else begin
                        w_emit = 1'b1;
                    end
                end

                c_S_ESC: begin
                    if (w_is_c0) begin
                        w_emit = 1'b1;
                    end else if (w_is_esc) begin
                        w_state_n = c_S_ESC;
                    end else if (data == 8'h5B) begin
                        w_state_n   = c_S_CSI_ENTRY;
                        w_wparams_n = '0;
                        w_wdef_n    = '1;
                        w_idx_n     = '0;
                        w_seen_n    = 1'b0;
                        w_priv_n    = 1'b0;
                        w_ovf_n     = 1'b0;
                    end else if ((data >= 8'h30) && (data <= 8'h7E)) begin
                        w_emit    = 1'b1;
                        w_kind    = c_KIND_ESC;
                        w_state_n = c_S_IDLE;
                    end else begin
                        w_state_n = c_S_IDLE;
                    end
                end

                default: begin  // CSI_ENTRY and CSI_PARAM share byte handling
                    if (w_is_c0) begin
                        w_emit = 1'b1;
                    end else if (w_is_esc) begin
                        w_state_n = c_S_ESC;
                    end else if (w_is_cancel) begin
                        w_state_n = c_S_IDLE;
                    end else if ((r_state == c_S_CSI_ENTRY) && (data == 8'h3F)) begin
                        w_priv_n  = 1'b1;
                        w_state_n = c_S_CSI_PARAM;
                    end else if (w_is_digit) begin
                        w_state_n = c_S_CSI_PARAM;
                        w_seen_n  = 1'b1;
                        if (r_idx < c_MAXP) begin
                            for (int i = 0; i < MAX_PARAMS; i++) begin
                                if (CNT_W'(i) == r_idx) begin
                                    w_wparams_n[i*PARAM_W +: PARAM_W] = w_sat;
                                    w_wdef_n[i]                       = 1'b0;
                                end
                            end
                        end else begin
                            w_ovf_n = 1'b1;
                        end
                    end else if (data == 8'h3B) begin
                        w_state_n = c_S_CSI_PARAM;
                        w_seen_n  = 1'b1;
                        if (r_idx < c_MAXP) begin
                            w_idx_n = r_idx + CNT_W'(1);
                        end
                        // Closing the last slot means a further parameter exists
                        if (r_idx >= c_MAXP - CNT_W'(1)) begin
                            w_ovf_n = 1'b1;
                        end
                    end else if (w_is_final) begin
                        w_emit    = 1'b1;
                        w_kind    = c_KIND_CSI;
                        w_state_n = c_S_IDLE;
                    end else begin
                        w_state_n = c_S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_S_IDLE;
            r_wparams <= '0;
            r_wdef    <= '1;
            r_idx     <= '0;
            r_seen    <= 1'b0;
            r_priv    <= 1'b0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_kind    <= c_KIND_CHAR;
            r_final   <= 8'h00;
            r_opriv   <= 1'b0;
            r_ocount  <= '0;
            r_oparams <= '0;
            r_odef    <= '1;
            r_oovf    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_wparams <= w_wparams_n;
            r_wdef    <= w_wdef_n;
            r_idx     <= w_idx_n;
            r_seen    <= w_seen_n;
            r_priv    <= w_priv_n;
            r_ovf     <= w_ovf_n;
            r_valid   <= w_emit;
            r_busy    <= (w_state_n != c_S_IDLE);
            if (w_emit) begin
                r_kind  <= w_kind;
                r_final <= data;
                if (w_kind == c_KIND_CSI) begin
                    r_opriv   <= r_priv;
                    r_ocount  <= w_pcount;
                    r_oparams <= r_wparams;
                    r_odef    <= r_wdef;
                    r_oovf    <= r_ovf;
                end else begin
                    r_opriv   <= 1'b0;
                    r_ocount  <= '0;
                    r_oparams <= '0;
                    r_odef    <= '1;
                    r_oovf    <= 1'b0;
                end
            end
        end
    end

    assign cmdValid      = r_valid;
    assign cmdKind       = r_kind;
    assign cmdFinal      = r_final;
    assign cmdPrivate    = r_opriv;
    assign paramCount    = r_ocount;
    assign params        = r_oparams;
    assign paramDefault  = r_odef;
    assign paramOverflow = r_oovf;
    assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_csi_sequence_parser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csi_sequence_parser
//  Purpose  : Directed-vector bench for csi_sequence_parser. Expected events
//             are queued when the terminating byte is driven; a monitor pops
//             and compares on every cmdValid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csi_sequence_parser;

    localparam int MAX_PARAMS = 4;
    localparam int PARAM_W    = 8;
    localparam int CNT_W      = 3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  fin;
        logic        priv;
        logic [2:0]  cnt;
        logic [31:0] prm;
        logic [3:0]  def;
        logic        ovf;
    } ev_t;

    logic        clk;
    logic        rst;
    logic [7:0]  data;
    logic        dataReady;
    logic        cmdValid;
    logic [1:0]  cmdKind;
    logic [7:0]  cmdFinal;
    logic        cmdPrivate;
    logic [2:0]  paramCount;
    logic [31:0] params;
    logic [3:0]  paramDefault;
    logic        paramOverflow;
    logic        busy;

    int  vectors    = 0;
    int  miscompares = 0;
    ev_t sb[$];

    csi_sequence_parser #(
        .MAX_PARAMS (MAX_PARAMS),
        .PARAM_W    (PARAM_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data          (data),
        .dataReady     (dataReady),
        .cmdValid      (cmdValid),
        .cmdKind       (cmdKind),
        .cmdFinal      (cmdFinal),
        .cmdPrivate    (cmdPrivate),
        .paramCount    (paramCount),
        .params        (params),
        .paramDefault  (paramDefault),
        .paramOverflow (paramOverflow),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ev_t ev_char(input logic [7:0] b);
        return '{kind: 2'd0, fin: b, priv: 1'b0, cnt: 3'd0, prm: 32'h0, def: 4'hF, ovf: 1'b0};
    endfunction

    function automatic ev_t ev_esc(input logic [7:0] b);
        return '{kind: 2'd1, fin: b, priv: 1'b0, cnt: 3'd0, prm: 32'h0, def: 4'hF, ovf: 1'b0};
    endfunction

    function automatic ev_t ev_csi(input logic [7:0] b, input logic p, input logic [2:0] c,
                                   input logic [31:0] prm, input logic [3:0] d, input logic o);
        return '{kind: 2'd2, fin: b, priv: p, cnt: c, prm: prm, def: d, ovf: o};
    endfunction

    task automatic send(input logic [7:0] b);
        data      = b;
        dataReady = 1'b1;
        @(posedge clk);
        #1;
        dataReady = 1'b0;
    endtask

    // Bytes are taken most-significant first from v
    task automatic send_n(input logic [95:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send(v[(n-1-i)*8 +: 8]);
        end
    endtask

    task automatic check_busy(input string name, input logic exp);
        @(negedge clk);
        vectors++;
        if (busy !== exp) begin
            miscompares++;
            $display("FAIL %s: busy got %b expected %b", name, busy, exp);
        end
    endtask

    // Monitor: every cmdValid must match the oldest queued expectation
    initial begin
        ev_t got;
        ev_t exp;
        forever begin
            @(negedge clk);
            if (cmdValid === 1'b1) begin
                got = '{kind: cmdKind, fin: cmdFinal, priv: cmdPrivate, cnt: paramCount,
                        prm: params, def: paramDefault, ovf: paramOverflow};
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got kind=%0d final=%h cnt=%0d params=%h def=%b ovf=%b, expected none",
                             got.kind, got.fin, got.cnt, got.prm, got.def, got.ovf);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        miscompares++;
                        $display("FAIL event_%h: got kind=%0d final=%h priv=%b cnt=%0d params=%h def=%b ovf=%b, expected kind=%0d final=%h priv=%b cnt=%0d params=%h def=%b ovf=%b",
                                 exp.fin, got.kind, got.fin, got.priv, got.cnt, got.prm, got.def, got.ovf,
                                 exp.kind, exp.fin, exp.priv, exp.cnt, exp.prm, exp.def, exp.ovf);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        data      = 8'h00;
        dataReady = 1'b1;   // reset must win over a pending byte
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({cmdValid, cmdKind, cmdFinal, cmdPrivate, paramCount, params, paramDefault, paramOverflow, busy}
            !== {1'b0, 2'd0, 8'h00, 1'b0, 3'd0, 32'h0, 4'hF, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b k=%0d f=%h p=%b c=%0d prm=%h d=%b o=%b busy=%b, expected all zero with def=1111",
                     cmdValid, cmdKind, cmdFinal, cmdPrivate, paramCount, params, paramDefault, paramOverflow, busy);
        end
        dataReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset mid-sequence discards the partial CSI
        send_n(96'h1B5B33, 3);
        check_busy("busy_mid_seq", 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_busy("busy_after_reset", 1'b0);
        sb.push_back(ev_char(8'h41));
        send(8'h41);

        // Plain character and two-byte ESC command
        sb.push_back(ev_char(8'h5A));
        send(8'h5A);
        sb.push_back(ev_esc(8'h37));
        send_n(96'h1B37, 2);

        // Two parameters at full byte rate
        sb.push_back(ev_csi(8'h48, 1'b0, 3'd2, 32'h0000_220C, 4'b1100, 1'b0));
        send_n(96'h1B5B_3132_3B33_3448, 8);
        check_busy("busy_idle_after_csi", 1'b0);

        // Leading empty parameter, then no parameters at all
        sb.push_back(ev_csi(8'h66, 1'b0, 3'd2, 32'h0000_0500, 4'b1101, 1'b0));
        send_n(96'h1B5B3B3566, 5);
        sb.push_back(ev_csi(8'h4A, 1'b0, 3'd0, 32'h0, 4'b1111, 1'b0));
        send_n(96'h1B5B4A, 3);

        // Private marker, then saturation
        sb.push_back(ev_csi(8'h6C, 1'b1, 3'd1, 32'h0000_0019, 4'b1110, 1'b0));
        send_n(96'h1B5B3F32356C, 6);
        sb.push_back(ev_csi(8'h41, 1'b0, 3'd1, 32'h0000_00FF, 4'b1110, 1'b0));
        send_n(96'h1B5B39393941, 6);

        // More parameters than slots
        sb.push_back(ev_csi(8'h6D, 1'b0, 3'd4, 32'h0403_0201, 4'b0000, 1'b0 | 1'b1));
        send_n(96'h1B5B_313B_323B_333B_343B_356D, 12);

        // C0 control executed inside a CSI sequence
        sb.push_back(ev_char(8'h0A));
        send_n(96'h1B5B320A, 4);
        sb.push_back(ev_csi(8'h4B, 1'b0, 3'd1, 32'h0000_0002, 4'b1110, 1'b0));
        send(8'h4B);

        // ESC aborts a CSI and starts a new ESC command
        sb.push_back(ev_esc(8'h44));
        send_n(96'h1B5B321B44, 5);

        // CAN aborts silently; following byte is a plain char
        send_n(96'h1B5B3118, 4);
        sb.push_back(ev_char(8'h41));
        send(8'h41);

        // Drain the scoreboard within a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d events outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
